// File: rtl/nfu12_tile_acc_pipe.sv
// nfu12_tile_acc_pipe: Tn x Tn synapse MAC tile with row sum/max reduction,
// local multi-beat accumulation and saturating fixed-point output.
module nfu12_tile_acc_pipe #(
    parameter int N    = 16,
    parameter int Tn   = 16,
    parameter int FRAC = 8,
    parameter int ACCW = 2*N+$clog2(Tn)+4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic                  i_stall,
    input  logic                  i_op,
    input  logic                  i_first,
    input  logic                  i_last,
    input  logic [N*Tn-1:0]       i_inputs,
    input  logic [N*Tn*Tn-1:0]    i_synapses,
    input  logic [N*Tn-1:0]       i_nbout,
    output logic                  o_valid,
    output logic [N*Tn-1:0]       o_to_nbout,
    output logic                  o_sat,
    output logic                  o_busy
);

    logic                   s1_v, s1_op, s1_first, s1_last;
    logic [N*Tn-1:0]        s1_in, s1_nb;
    logic [N*Tn*Tn-1:0]     s1_syn;

    logic                   s2_v, s2_op, s2_first, s2_last;
    logic [N*Tn-1:0]        s2_nb;
    logic signed [2*N-1:0]  prod [Tn*Tn];
    logic signed [2*N-1:0]  s2_p [Tn*Tn];

    logic                   s3_v, s3_op, s3_first, s3_last;
    logic [N*Tn-1:0]        s3_nb;
    logic signed [ACCW-1:0] red  [Tn];
    logic signed [ACCW-1:0] s3_r [Tn];

    logic signed [ACCW-1:0] acc  [Tn];
    logic signed [ACCW-1:0] nxt  [Tn];

    logic                   s4_v, s4_last;
    logic signed [ACCW-1:0] s4_sh [Tn];
    logic [N*Tn-1:0]        sat_val;
    logic [Tn-1:0]          clamp;

    // S2 products: each lane j input times synapse (i,j), exact at 2N bits
    for (genvar k = 0; k < Tn*Tn; k++) begin : g_mul
        localparam int J = k % Tn;
        logic signed [2*N-1:0] a, b;
        assign a = (2*N)'($signed(s1_in[N*J +: N]));
        assign b = (2*N)'($signed(s1_syn[N*k +: N]));
        assign prod[k] = a * b;
    end

    // S3 row reduction and S4 combine, one copy per output lane
    for (genvar i = 0; i < Tn; i++) begin : g_lane
        logic signed [ACCW-1:0] sum, mx, base, sh;
        logic hi, lo;

        // Row sum and row max computed side by side; op selects
        always_comb begin
            sum = '0;
            mx  = ACCW'(s2_p[i*Tn]);
            for (int j = 0; j < Tn; j++) begin
                sum = sum + ACCW'(s2_p[i*Tn+j]);
                if (ACCW'(s2_p[i*Tn+j]) > mx)
                    mx = ACCW'(s2_p[i*Tn+j]);
            end
        end
        assign red[i] = s2_op ? mx : sum;

        assign base = s3_first ?
                      (ACCW'($signed(s3_nb[N*i +: N])) <<< FRAC) : acc[i];
        assign nxt[i] = s3_op ? ((s3_r[i] > base) ? s3_r[i] : base)
                              : base + s3_r[i];

        // Fits in N bits only when all bits from N-1 upward agree
        assign sh = s4_sh[i];
        assign hi = !sh[ACCW-1] && (|sh[ACCW-2:N-1]);
        assign lo = sh[ACCW-1] && !(&sh[ACCW-2:N-1]);
        assign clamp[i] = hi | lo;
        assign sat_val[N*i +: N] = hi ? {1'b0, {(N-1){1'b1}}} :
                                   lo ? {1'b1, {(N-1){1'b0}}} :
                                        sh[N-1:0];
    end

    // S1: capture the beat
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v     <= 1'b0;
            s1_op    <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
        end else if (!i_stall) begin
            s1_v     <= i_valid;
            s1_op    <= i_op;
            s1_first <= i_first;
            s1_last  <= i_last;
            s1_in    <= i_inputs;
            s1_syn   <= i_synapses;
            s1_nb    <= i_nbout;
        end
    end

    // S2: register the product array
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v     <= 1'b0;
            s2_op    <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
        end else if (!i_stall) begin
            s2_v     <= s1_v;
            s2_op    <= s1_op;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s2_nb    <= s1_nb;
            s2_p     <= prod;
        end
    end

    // S3: register the per-row reductions
    always_ff @(posedge clk) begin
        if (rst) begin
            s3_v     <= 1'b0;
            s3_op    <= 1'b0;
            s3_first <= 1'b0;
            s3_last  <= 1'b0;
        end else if (!i_stall) begin
            s3_v     <= s3_v_next();
            s3_op    <= s2_op;
            s3_first <= s2_first;
            s3_last  <= s2_last;
            s3_nb    <= s2_nb;
            s3_r     <= red;
        end
    end

    function automatic logic s3_v_next();
        return s2_v;
    endfunction

    // S4: accumulator read-modify-write and scaled result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            s4_v    <= 1'b0;
            s4_last <= 1'b0;
            for (int i = 0; i < Tn; i++) begin
                acc[i]   <= '0;
                s4_sh[i] <= '0;
            end
        end else if (!i_stall) begin
            s4_v    <= s3_v;
            s4_last <= s3_last;
            if (s3_v) begin
                for (int i = 0; i < Tn; i++) begin
                    acc[i]   <= nxt[i];
                    s4_sh[i] <= nxt[i] >>> FRAC;
                end
            end
        end
    end

    // Output: pulse on group end, results hold between groups
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid    <= 1'b0;
            o_sat      <= 1'b0;
            o_to_nbout <= '0;
        end else if (!i_stall) begin
            o_valid <= s4_v & s4_last;
            if (s4_v && s4_last) begin
                o_to_nbout <= sat_val;
                o_sat      <= |clamp;
            end
        end
    end

    assign o_busy = s1_v | s2_v | s3_v | s4_v;

endmodule
